// File: rtl/rr_mask_arbiter.sv
// rtl/rr_mask_arbiter.sv - round-robin arbiter, masked/unmasked dual priority
// Registered one-hot grant with rotating pointer, software pointer load and optional grant lock.
module rr_mask_arbiter #(
  parameter int N    = 4,
  parameter bit LOCK = 1'b0,
  parameter int IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ptr_load,
  input  logic [IW-1:0] ptr_in,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] ptr
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [IW:0]   N_W  = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  masked;
  logic          any_m, any_r, hold;
  logic [IW-1:0] win_m, win_r, win;

  // Masked pass looks at requests at or above ptr; the unmasked pass is the fallback.
  always_comb begin
    masked = '0;
    any_m  = 1'b0;
    any_r  = 1'b0;
    win_m  = '0;
    win_r  = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr_q));
    end
    for (int i = N-1; i >= 0; i--) begin
      if (masked[i]) begin
        win_m = IW'(i);
        any_m = 1'b1;
      end
      if (req[i]) begin
        win_r = IW'(i);
        any_r = 1'b1;
      end
    end
    win = any_m ? win_m : win_r;
  end

  assign hold = LOCK && (state_q == OWNED) && req[idx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (!hold) begin
      if (any_r) begin
        state_d      = OWNED;
        grant_d      = '0;
        grant_d[win] = 1'b1;
        idx_d        = win;
        ptr_d        = (win == LAST) ? '0 : win + IW'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    end
    // Software load wins over auto-advance; out-of-range values fold to 0.
    if (ptr_load) begin
      ptr_d = ({1'b0, ptr_in} >= N_W) ? '0 : ptr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == OWNED);
  assign grant_idx   = idx_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_rr_mask_arbiter.sv
// tb/tb_rr_mask_arbiter.sv - randomized and directed bench for rr_mask_arbiter
// Three instances (N=4 free, N=4 locked, N=3 free) against a rotating-search reference model.
module tb_rr_mask_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req0, req1;
  logic [2:0] req2;
  logic ld0, ld1, ld2;
  logic [1:0] pin0, pin1, pin2;
  logic [3:0] g0, g1;
  logic [2:0] g2;
  logic gv0, gv1, gv2;
  logic [1:0] gi0, gi1, gi2, p0, p1, p2;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr[3];
  int m_own[3];
  int nx_ptr[3];
  int nx_own[3];

  always #5 clk = ~clk;

  rr_mask_arbiter #(.N(4), .LOCK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .ptr_load(ld0), .ptr_in(pin0),
    .grant(g0), .grant_valid(gv0), .grant_idx(gi0), .ptr(p0));
  rr_mask_arbiter #(.N(4), .LOCK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .ptr_load(ld1), .ptr_in(pin1),
    .grant(g1), .grant_valid(gv1), .grant_idx(gi1), .ptr(p1));
  rr_mask_arbiter #(.N(3), .LOCK(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .ptr_load(ld2), .ptr_in(pin2),
    .grant(g2), .grant_valid(gv2), .grant_idx(gi2), .ptr(p2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: scan requesters in rotated order starting at ptr; first hit wins.
  task automatic model_one(input int d, input int n, input bit lock,
                           input logic [31:0] rq, input logic ld, input int pin);
    int p, o, w;
    p = m_ptr[d];
    o = m_own[d];
    if (!rst_n) begin
      p = 0;
      o = -1;
    end else begin
      if (!(lock && o >= 0 && rq[o])) begin
        w = -1;
        for (int k = 0; k < n; k++) begin
          if (w < 0 && rq[(p + k) % n]) w = (p + k) % n;
        end
        o = w;
        if (w >= 0) p = (w + 1) % n;
      end
      if (ld) p = (pin >= n) ? 0 : pin;
    end
    nx_ptr[d] = p;
    nx_own[d] = o;
  endtask

  task automatic check_dut(input int d, input logic [31:0] g, input logic gv,
                           input logic [31:0] gi, input logic [31:0] p);
    int o;
    o = m_own[d];
    check($sformatf("d%0d_grant", d), g, (o < 0) ? 32'd0 : (32'd1 << o));
    check($sformatf("d%0d_valid", d), {31'd0, gv}, (o < 0) ? 32'd0 : 32'd1);
    check($sformatf("d%0d_idx", d), gi, (o < 0) ? 32'd0 : o);
    check($sformatf("d%0d_ptr", d), p, m_ptr[d]);
  endtask

  task automatic step();
    model_one(0, 4, 1'b0, {28'd0, req0}, ld0, int'(pin0));
    model_one(1, 4, 1'b1, {28'd0, req1}, ld1, int'(pin1));
    model_one(2, 3, 1'b0, {29'd0, req2}, ld2, int'(pin2));
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = nx_ptr[d];
      m_own[d] = nx_own[d];
    end
    check_dut(0, {28'd0, g0}, gv0, {30'd0, gi0}, {30'd0, p0});
    check_dut(1, {28'd0, g1}, gv1, {30'd0, gi1}, {30'd0, p1});
    check_dut(2, {29'd0, g2}, gv2, {30'd0, gi2}, {30'd0, p2});
  endtask

  initial begin
    int rot_g[5] = '{1, 2, 4, 8, 1};
    int rot_p[5] = '{1, 2, 3, 0, 1};
    int n3_g[4]  = '{1, 2, 4, 1};
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0;
      m_own[d] = -1;
    end

    // Reset with everything asserted
    rst_n = 1'b0;
    req0 = 4'b1111; req1 = 4'b1111; req2 = 3'b111;
    ld0 = 1'b1; ld1 = 1'b1; ld2 = 1'b1;
    pin0 = 2'd2; pin1 = 2'd2; pin2 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", {28'd0, g0}, 32'd0);
      check("rst_ptr", {30'd0, p0}, 32'd0);
    end
    rst_n = 1'b1;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;

    // Rotation with all requesting
    for (int i = 0; i < 5; i++) begin
      step();
      check("rot_grant", {28'd0, g0}, rot_g[i]);
      check("rot_ptr", {30'd0, p0}, rot_p[i]);
    end

    // Wrap and fallback; also park dut1 at ptr 0
    req0 = 4'b0000; ld0 = 1'b1; pin0 = 2'd3;
    req1 = 4'b0000; ld1 = 1'b1; pin1 = 2'd0;
    step();
    ld0 = 1'b0; ld1 = 1'b0; req0 = 4'b0011;
    step();
    check("wrap_grant0", {28'd0, g0}, 32'd1);
    check("wrap_ptr0", {30'd0, p0}, 32'd1);
    step();
    check("wrap_grant1", {28'd0, g0}, 32'd2);
    check("wrap_ptr1", {30'd0, p0}, 32'd2);
    step();
    check("wrap_grant2", {28'd0, g0}, 32'd1);

    // Lock hold, hand-over, release
    req1 = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_grant", {28'd0, g1}, 32'd1);
      check("lock_ptr", {30'd0, p1}, 32'd1);
    end
    req1 = 4'b0100;
    step();
    check("lock_handover", {28'd0, g1}, 32'd4);
    check("lock_idx", {30'd0, gi1}, 32'd2);
    check("lock_ptr3", {30'd0, p1}, 32'd3);
    req1 = 4'b0000;
    step();
    check("lock_idle", {28'd0, g1}, 32'd0);
    check("lock_idle_valid", {31'd0, gv1}, 32'd0);

    // Load collides with a new grant
    req0 = 4'b0000; ld0 = 1'b1; pin0 = 2'd0;
    step();
    req0 = 4'b0110; pin0 = 2'd3;
    step();
    check("coll_grant", {28'd0, g0}, 32'd2);
    check("coll_ptr", {30'd0, p0}, 32'd3);
    ld0 = 1'b0;
    step();
    check("coll_fallback", {28'd0, g0}, 32'd2);

    // Non-power-of-2 out-of-range load and rotation
    req2 = 3'b000; ld2 = 1'b1; pin2 = 2'd3;
    step();
    check("n3_oor_ptr", {30'd0, p2}, 32'd0);
    ld2 = 1'b0; req2 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      check("n3_rot", {29'd0, g2}, n3_g[i]);
    end

    // Random traffic with occasional reset and pointer loads
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) req0 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req1 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req2 = 3'($urandom);
      ld0 = ($urandom_range(0, 7) == 0);
      ld1 = ($urandom_range(0, 7) == 0);
      ld2 = ($urandom_range(0, 7) == 0);
      pin0 = 2'($urandom);
      pin1 = 2'($urandom);
      pin2 = 2'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
